// File: rtl/impor_host.sv
// Initiator for one IMPOR instance: buffers nine host operands, streams them
// on launch, then captures nine result beats into a host-readable buffer.
module impor_host #(
    parameter int BEATS   = 9,
    parameter int DW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          go,
    input  logic [DW-1:0] go_mode,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [DW-1:0] imp_in,
    output logic [DW-1:0] imp_mode,
    output logic          imp_in_valid,
    input  logic          imp_ready,
    input  logic [DW-1:0] imp_out,
    input  logic          imp_out_valid
);

    localparam logic [3:0] N_BEATS = 4'(BEATS);
    localparam logic [7:0] T_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        SEND,
        RECV,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [DW-1:0] op  [BEATS];
    logic [DW-1:0] res [BEATS];
    logic [3:0]    cnt;
    logic [3:0]    sidx;
    logic [3:0]    rcnt;
    logic [7:0]    tcnt;
    logic [DW-1:0] mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            sidx         <= 4'd0;
            rcnt         <= 4'd0;
            tcnt         <= 8'd0;
            mode_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            imp_in       <= '0;
            imp_mode     <= '0;
            imp_in_valid <= 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                op[i]  <= '0;
                res[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, LOAD: begin
                    // A launch takes priority over a simultaneous (and thus surplus) load.
                    if (state == LOAD && go && cnt == N_BEATS) begin
                        mode_q <= go_mode;
                        rcnt   <= 4'd0;
                        busy   <= 1'b1;
                        state  <= WAIT_RDY;
                    end else if (ld_valid && cnt != N_BEATS) begin
                        op[cnt] <= ld_data;
                        cnt     <= cnt + 4'd1;
                        state   <= LOAD;
                    end
                end
                WAIT_RDY: begin
                    if (imp_ready) begin
                        imp_in_valid <= 1'b1;
                        imp_in       <= op[0];
                        imp_mode     <= mode_q;
                        sidx         <= 4'd1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    // The stream is not gated by ready once started.
                    if (sidx == N_BEATS) begin
                        imp_in_valid <= 1'b0;
                        imp_in       <= '0;
                        imp_mode     <= '0;
                        tcnt         <= 8'd0;
                        state        <= RECV;
                    end else begin
                        imp_in   <= op[sidx];
                        imp_mode <= '0;
                        sidx     <= sidx + 4'd1;
                    end
                end
                RECV: begin
                    if (imp_out_valid) begin
                        res[rcnt] <= imp_out;
                        rcnt      <= rcnt + 4'd1;
                        tcnt      <= 8'd0;
                        if (rcnt == N_BEATS - 4'd1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt == T_LAST) begin
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                            state   <= ERR;
                        end
                    end
                end
                DONE, ERR: begin
                    if (ld_valid) begin
                        op[0]   <= ld_data;
                        cnt     <= 4'd1;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < N_BEATS) rd_data = res[rd_addr];
    end

endmodule
